// File: rtl/x_system.sv
// Two-stage registered power/polynomial unit: Z = f(x) for x^2, x^3, x^4 or x^4+x^3+x^2+x+1.
// Optional parity output z_par is enabled by defining X_SYS_PARITY_EN.
module x_system #(
   parameter int X_W = 5,
   parameter int Z_W = 22
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [X_W-1:0] X,
   input  logic [1:0]     Sel,
   input  logic           x_type,
   input  logic           in_vld,
   output logic [Z_W-1:0] Z,
   output logic           z_vld
`ifdef X_SYS_PARITY_EN
   ,
   output logic           z_par
`endif
);

   logic [X_W-1:0] r_x;
   logic [1:0]     r_sel;
   logic           r_type;
   logic           r_vld;

   logic [Z_W-1:0] w_xe;
   logic [Z_W-1:0] w_x2;
   logic [Z_W-1:0] w_x3;
   logic [Z_W-1:0] w_x4;
   logic [Z_W-1:0] w_poly;
   logic [Z_W-1:0] w_zNext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_sel  <= '0;
         r_type <= 1'b0;
         r_vld  <= 1'b0;
      end else begin
         r_x    <= X;
         r_sel  <= Sel;
         r_type <= x_type;
         r_vld  <= in_vld;
      end
   end

   // Two's-complement products keep the same low bits whether the operand is signed or not,
   // so extending x to Z_W bits once is enough for both output formats.
   assign w_xe   = {{(Z_W-X_W){r_type & r_x[X_W-1]}}, r_x};
   assign w_x2   = w_xe * w_xe;
   assign w_x3   = w_x2 * w_xe;
   assign w_x4   = w_x2 * w_x2;
   assign w_poly = w_x4 + w_x3 + w_x2 + w_xe + Z_W'(1);

   always_comb begin
      w_zNext = '0;
      case (r_sel)
         2'b00:   w_zNext = w_x2;
         2'b01:   w_zNext = w_x3;
         2'b10:   w_zNext = w_x4;
         default: w_zNext = w_poly;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Z     <= '0;
         z_vld <= 1'b0;
      end else begin
         Z     <= w_zNext;
         z_vld <= r_vld;
      end
   end

`ifdef X_SYS_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) z_par <= 1'b0;
      else        z_par <= ^w_zNext;
   end
`endif

endmodule

// File: tb/tb_x_system.sv
// Scoreboard bench for x_system: expected Z/z_vld queued at drive time, popped two cycles later.
// Checks z_par as well when X_SYS_PARITY_EN is defined.
module tb_x_system;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  X;
   logic [1:0]  Sel;
   logic        x_type;
   logic        in_vld;
   logic [21:0] Z;
   logic        z_vld;
`ifdef X_SYS_PARITY_EN
   logic        z_par;
`endif

   typedef struct {
      logic [21:0] z;
      logic        vld;
      string       tag;
   } exp_t;

   exp_t sbQ[$];
   int   errors = 0;
   int   checks = 0;

   x_system #(.X_W(5), .Z_W(22)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .X      (X),
      .Sel    (Sel),
      .x_type (x_type),
      .in_vld (in_vld),
      .Z      (Z),
      .z_vld  (z_vld)
`ifdef X_SYS_PARITY_EN
      ,
      .z_par  (z_par)
`endif
   );

   always #5 clk = ~clk;

   // Independent integer model of the four functions.
   function automatic logic [21:0] modelZ(input logic [4:0] x, input logic [1:0] s, input logic t);
      longint v;
      longint r;
      v = t ? longint'($signed(x)) : longint'(x);
      case (s)
         2'b00:   r = v * v;
         2'b01:   r = v * v * v;
         2'b10:   r = v * v * v * v;
         default: r = v * v * v * v + v * v * v + v * v + v + 1;
      endcase
      return r[21:0];
   endfunction

   task automatic compareEntry(input exp_t e);
      checks++;
      assert (Z === e.z) else begin
         errors++;
         $error("[TB] FAIL %s Z: got %0d (0x%h) expected %0d (0x%h)", e.tag, Z, Z, e.z, e.z);
      end
      checks++;
      assert (z_vld === e.vld) else begin
         errors++;
         $error("[TB] FAIL %s z_vld: got %b expected %b", e.tag, z_vld, e.vld);
      end
`ifdef X_SYS_PARITY_EN
      checks++;
      assert (z_par === ^e.z) else begin
         errors++;
         $error("[TB] FAIL %s z_par: got %b expected %b", e.tag, z_par, ^e.z);
      end
`endif
   endtask

   task automatic checkOutput(input bit drain);
      exp_t e;
      if (sbQ.size() >= 2 || (drain && sbQ.size() > 0)) begin
         e = sbQ.pop_front();
         compareEntry(e);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [4:0] x, input logic [1:0] s,
                                input logic t, input logic v, input logic [21:0] expZ);
      exp_t e;
      @(negedge clk);
      checkOutput(1'b0);
      X      = x;
      Sel    = s;
      x_type = t;
      in_vld = v;
      e.z    = expZ;
      e.vld  = v;
      e.tag  = tag;
      sbQ.push_back(e);
   endtask

   task automatic checkResetState(input string tag);
      checks++;
      assert (Z === 22'd0) else begin
         errors++;
         $error("[TB] FAIL %s Z: got 0x%h expected 0x000000", tag, Z);
      end
      checks++;
      assert (z_vld === 1'b0) else begin
         errors++;
         $error("[TB] FAIL %s z_vld: got %b expected 0", tag, z_vld);
      end
   endtask

   initial begin
      exp_t hold;
      logic [4:0] rx;
      logic [1:0] rs;
      logic       rt;

      rst_n  = 1'b0;
      X      = 5'd31;
      Sel    = 2'b10;
      x_type = 1'b0;
      in_vld = 1'b0;
      #1;
      checkResetState("reset_initial");

      // Release with held inputs; their result must surface with z_vld low before the first valid.
      @(negedge clk);
      rst_n = 1'b1;
      hold.z = 22'd923521; hold.vld = 1'b0; hold.tag = "post_reset_idle";
      sbQ.push_back(hold);
      applyStimulus("first_valid", 5'd3, 2'b00, 1'b0, 1'b1, 22'd9);

      applyStimulus("s00_u31", 5'd31, 2'b00, 1'b0, 1'b1, 22'd961);
      applyStimulus("s00_u1",  5'd1,  2'b00, 1'b0, 1'b1, 22'd1);
      applyStimulus("s00_u0",  5'd0,  2'b00, 1'b0, 1'b1, 22'd0);
      applyStimulus("s00_u9",  5'd9,  2'b00, 1'b0, 1'b1, 22'd81);
      applyStimulus("s00_u15", 5'd15, 2'b00, 1'b0, 1'b1, 22'd225);
      applyStimulus("s00_s31", 5'd31, 2'b00, 1'b1, 1'b1, 22'd1);
      applyStimulus("s00_s1",  5'd1,  2'b00, 1'b1, 1'b1, 22'd1);
      applyStimulus("s00_s0",  5'd0,  2'b00, 1'b1, 1'b1, 22'd0);
      applyStimulus("s00_s9",  5'd9,  2'b00, 1'b1, 1'b1, 22'd81);
      applyStimulus("s00_s15", 5'd15, 2'b00, 1'b1, 1'b1, 22'd225);

      applyStimulus("s01_u31", 5'd31, 2'b01, 1'b0, 1'b1, 22'd29791);
      applyStimulus("s01_s31", 5'd31, 2'b01, 1'b1, 1'b1, 22'h3FFFFF);
      applyStimulus("s01_s9",  5'd9,  2'b01, 1'b1, 1'b1, 22'd729);
      applyStimulus("s01_s15", 5'd15, 2'b01, 1'b1, 1'b1, 22'd3375);
      applyStimulus("s01_s0",  5'd0,  2'b01, 1'b1, 1'b1, 22'd0);
      applyStimulus("s01_sm16", 5'd16, 2'b01, 1'b1, 1'b1, 22'h3FF000);

      applyStimulus("s10_u31", 5'd31, 2'b10, 1'b0, 1'b1, 22'd923521);
      applyStimulus("s10_s31", 5'd31, 2'b10, 1'b1, 1'b1, 22'd1);
      applyStimulus("s10_u9",  5'd9,  2'b10, 1'b0, 1'b1, 22'd6561);
      applyStimulus("s10_u15", 5'd15, 2'b10, 1'b0, 1'b1, 22'd50625);
      applyStimulus("s10_sm16", 5'd16, 2'b10, 1'b1, 1'b1, 22'd65536);
      applyStimulus("s10_u0",  5'd0,  2'b10, 1'b0, 1'b1, 22'd0);

      applyStimulus("s11_u31", 5'd31, 2'b11, 1'b0, 1'b1, 22'd954305);
      applyStimulus("s11_s31", 5'd31, 2'b11, 1'b1, 1'b1, 22'd1);
      applyStimulus("s11_u9",  5'd9,  2'b11, 1'b0, 1'b1, 22'd7381);
      applyStimulus("s11_u15", 5'd15, 2'b11, 1'b0, 1'b1, 22'd54241);
      applyStimulus("s11_u0",  5'd0,  2'b11, 1'b0, 1'b1, 22'd1);

      // Mid-cycle reset while the pipeline holds nonzero results.
      applyStimulus("pre_reset", 5'd31, 2'b10, 1'b0, 1'b1, 22'd923521);
      applyStimulus("pre_reset2", 5'd31, 2'b10, 1'b0, 1'b1, 22'd923521);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetState("reset_midcycle");
      sbQ.delete();
      in_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      hold.z = 22'd923521; hold.vld = 1'b0; hold.tag = "post_reset2_idle";
      sbQ.push_back(hold);

      // Back-to-back random operands with in_vld toggling every cycle.
      for (int i = 0; i < 24; i++) begin
         rx = 5'($urandom_range(0, 31));
         rs = 2'($urandom_range(0, 3));
         rt = 1'($urandom_range(0, 1));
         applyStimulus($sformatf("b2b_%0d", i), rx, rs, rt, 1'(i % 2 == 0), modelZ(rx, rs, rt));
      end

      repeat (2) begin
         @(negedge clk);
         checkOutput(1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
